// File: rtl/mem_io_responder_if.sv
// CPU memory bus, host RX/TX byte streams and status flags of mem_io_responder.
// master = CPU/host side, slave = the responder itself.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        rdy_out;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halted;
  logic        tx_ovf;

  modport master (
    output mem_a, mem_wr, mem_wdata, rx_valid, rx_data, tx_ready,
    input  mem_rdata, rdy_out, rx_ready, tx_valid, tx_data, halted, tx_ovf
  );

  modport slave (
    input  mem_a, mem_wr, mem_wdata, rx_valid, rx_data, tx_ready,
    output mem_rdata, rdy_out, rx_ready, tx_valid, tx_data, halted, tx_ovf
  );
endinterface

// File: rtl/mem_io_responder.sv
// Memory/I/O responder for a byte-wide CPU: RAM below 0x30000, and at 0x30000
// an I/O window with RX/TX byte FIFOs, a free-running cycle counter with a
// snapshot register, and a sticky program-stop flag.
module mem_io_responder #(
  parameter int RAM_AW     = 17,
  parameter int FIFO_DEPTH = 8
) (
  input logic               clk_in,
  input logic               rst_in,
  mem_io_responder_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = PW - 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LIMIT_P = PW'(FIFO_DEPTH - 1);

  logic [7:0]        ram    [0:(1<<RAM_AW)-1];
  logic [7:0]        rx_mem [0:FIFO_DEPTH-1];
  logic [7:0]        tx_mem [0:FIFO_DEPTH-1];
  logic [PW-1:0]     rx_wp, rx_rp, tx_wp, tx_rp;
  logic [PW-1:0]     rx_cnt, tx_cnt;
  logic              rx_empty, rx_full, tx_empty, tx_full;
  logic              io_sel;
  logic [2:0]        io_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              rx_push, rx_pop, tx_req, tx_pop, tx_push;
  logic [7:0]        tx_byte;
  logic [7:0]        rdata_q;
  logic [31:0]       cyc_cnt;
  logic [23:0]       snap_hi;
  logic              halted_q, tx_ovf_q;
  logic              unused_addr;

  // Only bits 17:0 of the CPU address take part in decoding.
  assign unused_addr = ^bus.mem_a[31:18];

  assign io_sel  = (bus.mem_a[17:16] == 2'b11);
  assign io_off  = bus.mem_a[2:0];
  assign ram_idx = bus.mem_a[RAM_AW-1:0];

  assign rx_cnt   = rx_wp - rx_rp;
  assign tx_cnt   = tx_wp - tx_rp;
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == DEPTH_P);
  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == DEPTH_P);

  assign rx_push = bus.rx_valid && bus.rx_ready;
  assign rx_pop  = io_sel && !bus.mem_wr && (io_off == 3'd0) && !rx_empty;
  assign tx_req  = io_sel && bus.mem_wr &&
                   (((io_off == 3'd0) && (bus.mem_wdata != 8'h00)) || (io_off == 3'd4));
  assign tx_pop  = bus.tx_valid && bus.tx_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign tx_push = tx_req && (!tx_full || tx_pop);
  assign tx_byte = (io_off == 3'd4) ? 8'h00 : bus.mem_wdata;

  assign bus.mem_rdata = rdata_q;
  assign bus.rx_ready  = rst_in && !rx_full;
  assign bus.tx_valid  = !tx_empty;
  assign bus.tx_data   = tx_mem[tx_rp[IW-1:0]];
  assign bus.halted    = halted_q;
  assign bus.tx_ovf    = tx_ovf_q;
  // Leaves one TX slot free for a write already issued when the CPU stalls.
  assign bus.rdy_out   = rst_in && !halted_q && (tx_cnt < LIMIT_P);

  // RAM array is deliberately not reset.
  always_ff @(posedge clk_in) begin
    if (!io_sel && bus.mem_wr) ram[ram_idx] <= bus.mem_wdata;
  end

  // FIFO storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wp[IW-1:0]] <= bus.rx_data;
    if (tx_push) tx_mem[tx_wp[IW-1:0]] <= tx_byte;
  end

  // FIFO pointers, wrapping modulo twice the depth.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_wp <= '0;
      rx_rp <= '0;
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + PW'(1);
      if (rx_pop)  rx_rp <= rx_rp + PW'(1);
      if (tx_push) tx_wp <= tx_wp + PW'(1);
      if (tx_pop)  tx_rp <= tx_rp + PW'(1);
    end
  end

  // Cycle counter and the sticky halted / overflow flags.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cyc_cnt  <= 32'd0;
      halted_q <= 1'b0;
      tx_ovf_q <= 1'b0;
    end else begin
      if (!halted_q) cyc_cnt <= cyc_cnt + 32'd1;
      if (io_sel && bus.mem_wr && (io_off == 3'd4)) halted_q <= 1'b1;
      if (tx_req && !tx_push) tx_ovf_q <= 1'b1;
    end
  end

  // Registered read data; reading offset 4 snapshots the counter so the
  // upper bytes read afterwards belong to the same value.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rdata_q <= 8'h00;
      snap_hi <= 24'd0;
    end else if (!bus.mem_wr) begin
      if (!io_sel) begin
        rdata_q <= ram[ram_idx];
      end else begin
        case (io_off)
          3'd0:    rdata_q <= rx_empty ? 8'h00 : rx_mem[rx_rp[IW-1:0]];
          3'd4: begin
            rdata_q <= cyc_cnt[7:0];
            snap_hi <= cyc_cnt[31:8];
          end
          3'd5:    rdata_q <= snap_hi[7:0];
          3'd6:    rdata_q <= snap_hi[15:8];
          3'd7:    rdata_q <= snap_hi[23:16];
          default: rdata_q <= 8'h00;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: read data and TX bytes are
// checked against scoreboard queues filled as stimulus is driven.
module tb_mem_io_responder;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;

  mem_io_responder_if bus();

  mem_io_responder #(.RAM_AW(17), .FIFO_DEPTH(8)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  rd_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_model[$];
  logic [31:0] tb_cyc;
  logic        m_halt = 1'b0;
  logic [7:0]  mon_exp;

  // Reference cycle count: edges since reset release, frozen after halt.
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) tb_cyc <= 32'd0;
    else if (!m_halt) tb_cyc <= tb_cyc + 32'd1;
  end

  // TX scoreboard: a byte leaves whenever tx_valid && tx_ready at the next edge.
  always @(negedge clk_in) begin
    #1;
    if (rst_in === 1'b1 && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_extra: tx_data=%h but no byte expected", bus.tx_data);
      end else begin
        mon_exp = tx_q.pop_front();
        if (bus.tx_data !== mon_exp) begin
          errors++;
          $display("FAIL tx_data: got %h expected %h", bus.tx_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "watchdog");
  end

  // One CPU request cycle, then back to an idle RAM read of address 0.
  task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] wd);
    bus.mem_a = a; bus.mem_wr = wr; bus.mem_wdata = wd;
    @(posedge clk_in); #1;
    bus.mem_a = 32'h0; bus.mem_wr = 1'b0; bus.mem_wdata = 8'h00; bus.rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    bus.mem_a = 32'h0; bus.mem_wr = 1'b0; bus.mem_wdata = 8'h00;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b1;
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    got = {bus.mem_rdata, bus.tx_valid, bus.halted, bus.tx_ovf, bus.rx_ready, bus.rdy_out};
    checks++;
    if (got !== 13'h0) begin errors++; $display("FAIL reset_state: got %h expected 0000", got); end
    rst_in = 1'b1; #1;
    checks++;
    if ({bus.rx_ready, bus.rdy_out} !== 2'b11) begin
      errors++; $display("FAIL reset_release: rx_ready,rdy_out=%b expected 11", {bus.rx_ready, bus.rdy_out});
    end
    cyc(32'h0, 1'b0, 8'h00);
  endtask

  task automatic test_ram();
    logic [31:0] waddr[4];
    logic [7:0]  wdat[4];
    logic [31:0] raddr[4];
    logic [7:0]  rexp[4];
    logic [7:0]  e;
    waddr = '{32'h00123, 32'h1FFFF, 32'h2FFFF, 32'h30123};
    wdat  = '{8'hA5, 8'h5A, 8'hC3, 8'h77};
    raddr = '{32'h00123, 32'h1FFFF, 32'h0FFFF, 32'h00123};
    rexp  = '{8'hA5, 8'h5A, 8'hC3, 8'hA5};
    // read-after-write in the very next cycle
    cyc(waddr[0], 1'b1, wdat[0]);
    rd_q.push_back(8'hA5);
    cyc(32'h00123, 1'b0, 8'h00);
    e = rd_q.pop_front(); checks++;
    if (bus.mem_rdata !== e) begin errors++; $display("FAIL ram_raw: got %h expected %h", bus.mem_rdata, e); end
    for (int i = 1; i < 4; i++) cyc(waddr[i], 1'b1, wdat[i]);
    for (int i = 0; i < 4; i++) begin
      rd_q.push_back(rexp[i]);
      cyc(raddr[i], 1'b0, 8'h00);
      e = rd_q.pop_front(); checks++;
      if (bus.mem_rdata !== e) begin
        errors++; $display("FAIL ram_read[%0d]: addr %h got %h expected %h", i, raddr[i], bus.mem_rdata, e);
      end
    end
  endtask

  task automatic test_rx();
    logic [7:0] e;
    logic       exp_rdy;
    logic [7:0] seq[2];
    seq = '{8'h41, 8'h42};
    for (int i = 0; i < 2; i++) begin
      bus.rx_valid = 1'b1; bus.rx_data = seq[i];
      rx_model.push_back(seq[i]);
      cyc(32'h0, 1'b0, 8'h00);
    end
    for (int i = 0; i < 3; i++) begin
      rd_q.push_back(rx_model.size() != 0 ? rx_model.pop_front() : 8'h00);
      cyc(32'h30000, 1'b0, 8'h00);
      e = rd_q.pop_front(); checks++;
      if (bus.mem_rdata !== e) begin errors++; $display("FAIL rx_read[%0d]: got %h expected %h", i, bus.mem_rdata, e); end
    end
    // fill past capacity: the ninth byte must be refused
    for (int i = 0; i < 9; i++) begin
      exp_rdy = (rx_model.size() < 8);
      checks++;
      if (bus.rx_ready !== exp_rdy) begin
        errors++; $display("FAIL rx_ready[%0d]: got %b expected %b", i, bus.rx_ready, exp_rdy);
      end
      if (exp_rdy) rx_model.push_back(8'h80 + 8'(i));
      bus.rx_valid = 1'b1; bus.rx_data = 8'h80 + 8'(i);
      cyc(32'h0, 1'b0, 8'h00);
    end
    for (int i = 0; i < 10; i++) begin
      rd_q.push_back(rx_model.size() != 0 ? rx_model.pop_front() : 8'h00);
      cyc(32'h30000, 1'b0, 8'h00);
      e = rd_q.pop_front(); checks++;
      if (bus.mem_rdata !== e) begin errors++; $display("FAIL rx_drain[%0d]: got %h expected %h", i, bus.mem_rdata, e); end
    end
    rd_q.push_back(8'h00);
    cyc(32'h30002, 1'b0, 8'h00);
    e = rd_q.pop_front(); checks++;
    if (bus.mem_rdata !== e) begin errors++; $display("FAIL io_other: got %h expected %h", bus.mem_rdata, e); end
  endtask

  task automatic test_tx();
    logic [7:0] w[3];
    int         n;
    w = '{8'h48, 8'h00, 8'h49};
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (w[i] != 8'h00) tx_q.push_back(w[i]);
      cyc(32'h30000, 1'b1, w[i]);
    end
    n = 0;
    while (tx_q.size() != 0 && n < 10) begin cyc(32'h0, 1'b0, 8'h00); n++; end
    checks++;
    if (tx_q.size() != 0 || bus.tx_valid !== 1'b0) begin
      errors++; $display("FAIL tx_drain: %0d bytes left, tx_valid=%b expected 0 left and 0", tx_q.size(), bus.tx_valid);
    end
  endtask

  task automatic test_tx_full();
    int   cnt_m;
    logic ovf_m;
    int   n;
    cnt_m = 0; ovf_m = 1'b0;
    bus.tx_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (cnt_m < 8) begin tx_q.push_back(8'h60 + 8'(k)); cnt_m++; end
      else ovf_m = 1'b1;
      cyc(32'h30000, 1'b1, 8'h60 + 8'(k));
      checks++;
      if (bus.rdy_out !== (cnt_m < 7)) begin
        errors++; $display("FAIL rdy_out_fill[%0d]: got %b expected %b", k, bus.rdy_out, (cnt_m < 7));
      end
      checks++;
      if (bus.tx_ovf !== ovf_m) begin
        errors++; $display("FAIL tx_ovf_fill[%0d]: got %b expected %b", k, bus.tx_ovf, ovf_m);
      end
    end
    // full FIFO: push and pop in the same cycle are both taken
    bus.tx_ready = 1'b1;
    tx_q.push_back(8'h70);
    cyc(32'h30000, 1'b1, 8'h70);
    checks++;
    if (bus.rdy_out !== 1'b0) begin errors++; $display("FAIL full_pushpop_rdy: got %b expected 0", bus.rdy_out); end
    n = 0;
    while (tx_q.size() != 0 && n < 20) begin cyc(32'h0, 1'b0, 8'h00); n++; end
    checks++;
    if (tx_q.size() != 0) begin errors++; $display("FAIL tx_full_drain: %0d bytes left expected 0", tx_q.size()); end
    checks++;
    if ({bus.tx_ovf, bus.rdy_out} !== 2'b11) begin
      errors++; $display("FAIL tx_ovf_sticky: tx_ovf,rdy_out=%b expected 11", {bus.tx_ovf, bus.rdy_out});
    end
  endtask

  task automatic test_snap();
    logic [31:0] exp;
    logic [7:0]  e;
    int          n;
    n = 0;
    while (tb_cyc < 32'd300 && n < 1000) begin cyc(32'h0, 1'b0, 8'h00); n++; end
    exp = tb_cyc;
    for (int i = 0; i < 4; i++) begin
      rd_q.push_back(exp[8*i +: 8]);
      cyc(32'h30004 + 32'(i), 1'b0, 8'h00);
      e = rd_q.pop_front(); checks++;
      if (bus.mem_rdata !== e) begin
        errors++; $display("FAIL snap_byte[%0d]: got %h expected %h", i, bus.mem_rdata, e);
      end
    end
  endtask

  task automatic test_halt();
    logic [31:0] exp;
    logic [7:0]  e;
    logic [12:0] got;
    logic [31:0] ra[6];
    logic [7:0]  re[6];
    int          n;
    bus.tx_ready = 1'b1;
    tx_q.push_back(8'h00);
    cyc(32'h30004, 1'b1, 8'hFF);
    m_halt = 1'b1;
    checks++;
    if ({bus.halted, bus.rdy_out} !== 2'b10) begin
      errors++; $display("FAIL halt_flags: halted,rdy_out=%b expected 10", {bus.halted, bus.rdy_out});
    end
    n = 0;
    while (tx_q.size() != 0 && n < 10) begin cyc(32'h0, 1'b0, 8'h00); n++; end
    checks++;
    if (tx_q.size() != 0) begin errors++; $display("FAIL halt_tx: %0d bytes left expected 0", tx_q.size()); end
    cyc(32'h00200, 1'b1, 8'h77);
    exp = tb_cyc;
    ra = '{32'h30004, 32'h0, 32'h0, 32'h30004, 32'h30005, 32'h00200};
    re = '{exp[7:0], 8'h00, 8'h00, exp[7:0], exp[15:8], 8'h77};
    for (int i = 0; i < 6; i++) begin
      cyc(ra[i], 1'b0, 8'h00);
      if (i != 1 && i != 2) begin
        rd_q.push_back(re[i]);
        e = rd_q.pop_front(); checks++;
        if (bus.mem_rdata !== e) begin
          errors++; $display("FAIL halted_read[%0d]: got %h expected %h", i, bus.mem_rdata, e);
        end
      end
    end
    // leave bytes in both FIFOs, then reset mid-transfer
    bus.tx_ready = 1'b0;
    cyc(32'h30000, 1'b1, 8'h55);
    bus.rx_valid = 1'b1; bus.rx_data = 8'h99;
    cyc(32'h0, 1'b0, 8'h00);
    checks++;
    if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_tx_valid: got %b expected 1", bus.tx_valid); end
    rst_in = 1'b0; #1;
    m_halt = 1'b0;
    got = {bus.mem_rdata, bus.tx_valid, bus.halted, bus.tx_ovf, bus.rx_ready, bus.rdy_out};
    checks++;
    if (got !== 13'h0) begin errors++; $display("FAIL reset_pulse_state: got %h expected 0000", got); end
    @(posedge clk_in); #1;
    rst_in = 1'b1; #1;
    bus.tx_ready = 1'b1;
    checks++;
    if ({bus.rx_ready, bus.rdy_out, bus.tx_valid} !== 3'b110) begin
      errors++; $display("FAIL post_reset: rx_ready,rdy_out,tx_valid=%b expected 110", {bus.rx_ready, bus.rdy_out, bus.tx_valid});
    end
    rd_q.push_back(8'h00);
    cyc(32'h30000, 1'b0, 8'h00);
    e = rd_q.pop_front(); checks++;
    if (bus.mem_rdata !== e) begin errors++; $display("FAIL rx_discarded: got %h expected %h", bus.mem_rdata, e); end
    exp = tb_cyc;
    ra = '{32'h30004, 32'h30005, 32'h30006, 32'h30007, 32'h00123, 32'h00200};
    re = '{exp[7:0], exp[15:8], exp[23:16], exp[31:24], 8'hA5, 8'h77};
    for (int i = 0; i < 6; i++) begin
      rd_q.push_back(re[i]);
      cyc(ra[i], 1'b0, 8'h00);
      e = rd_q.pop_front(); checks++;
      if (bus.mem_rdata !== e) begin
        errors++; $display("FAIL post_reset_read[%0d]: got %h expected %h", i, bus.mem_rdata, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_rx();
    test_tx();
    test_tx_full();
    test_snap();
    test_halt();
    repeat (3) cyc(32'h0, 1'b0, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
